// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed storage behind a req/ready/ack
// handshake with a fixed number of wait states per access.
//
//   state  | meaning
//   IDLE   | ready high, waiting for a request
//   WAIT   | request latched, counting down wait states
//   RESP   | one-cycle ack with rdata/err valid
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  // With zero wait states the access completes on the accepting edge, so
  // the live inputs are used instead of the (not yet loaded) latches.
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        fault;
  logic [AW-1:0] idx;

  assign acc_we    = (state == S_IDLE) ? we    : lat_we;
  assign acc_addr  = (state == S_IDLE) ? addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? wdata : lat_wdata;
  assign acc_be    = (state == S_IDLE) ? be    : lat_be;
  assign fault     = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
  assign idx       = acc_addr[AW+1:2];

  assign ready = (state == S_IDLE);
  assign ack   = (state == S_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, memory access on the edge entering RESP, response data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      if (state == S_IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      if (state_next == S_RESP && state != S_RESP) begin
        if (fault) begin
          err_q <= 1'b1;
        end else if (acc_we) begin
          for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
          end
        end else begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

endmodule
